// File: rtl/traffic_pkg.sv
// Shared types and default timing for the N-approach traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    StAllRed,
    StGreen,
    StYellow,
    StFlash
  } tl_state_e;

  localparam int unsigned DefNumPhases = 4;
  localparam int unsigned DefMinGreen  = 4;
  localparam int unsigned DefMaxGreen  = 10;
  localparam int unsigned DefYellow    = 3;
  localparam int unsigned DefAllRed    = 2;
  localparam int unsigned DefFlashHalf = 2;
  localparam int unsigned DefTimerW    = 8;

  // Width of an approach index; never below one bit.
  function automatic int unsigned phase_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational round-robin search for the next approach with a pending request.
module tl_rr_picker
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES = DefNumPhases
) (
  input  logic [NUM_PHASES-1:0]              pend_i,
  input  logic [phase_width(NUM_PHASES)-1:0] active_i,
  output logic [phase_width(NUM_PHASES)-1:0] next_phase_o,
  output logic                               any_other_o
);

  localparam int unsigned PhaseW = phase_width(NUM_PHASES);
  localparam int unsigned IdxW   = PhaseW + 1;

  logic [IdxW-1:0]   idx_wide;
  logic [PhaseW-1:0] idx;
  logic              found;

  // Scans active+1 .. active+N-1 (mod N); the active approach itself is never a candidate,
  // so an empty search leaves the grant where it is.
  always_comb begin
    next_phase_o = active_i;
    found        = 1'b0;
    idx_wide     = '0;
    idx          = '0;
    for (int k = 1; k < NUM_PHASES; k++) begin
      idx_wide = {1'b0, active_i} + IdxW'(k);
      if (idx_wide >= IdxW'(NUM_PHASES)) begin
        idx_wide = idx_wide - IdxW'(NUM_PHASES);
      end
      idx = idx_wide[PhaseW-1:0];
      if (pend_i[idx] && !found) begin
        found        = 1'b1;
        next_phase_o = idx;
      end
    end
    any_other_o = found;
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach traffic light controller: round-robin service of demanded approaches with
// min/max green, yellow and all-red clearance, plus a night-flash mode.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = DefNumPhases,
  parameter int unsigned MIN_GREEN   = DefMinGreen,
  parameter int unsigned MAX_GREEN   = DefMaxGreen,
  parameter int unsigned YELLOW_TIME = DefYellow,
  parameter int unsigned ALLRED_TIME = DefAllRed,
  parameter int unsigned FLASH_HALF  = DefFlashHalf,
  parameter int unsigned TIMER_W     = DefTimerW
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic [NUM_PHASES-1:0]         req,
  input  logic                          flash_en,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          flash_active
);

  localparam int unsigned PhaseW = phase_width(NUM_PHASES);
  typedef logic [PhaseW-1:0] phase_t;

  localparam logic [TIMER_W-1:0] MinGreenM1 = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MaxGreenM1 = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YellowM1   = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AllRedM1   = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] FlashHalfT = TIMER_W'(FLASH_HALF);
  localparam logic [TIMER_W-1:0] FlashLastT = TIMER_W'(2 * FLASH_HALF - 1);

  tl_state_e             state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  phase_t                active_q, active_d;
  logic [NUM_PHASES-1:0] pend_q, pend_d;
  logic [NUM_PHASES-1:0] green_q, green_d;
  logic [NUM_PHASES-1:0] yellow_q, yellow_d;
  logic [NUM_PHASES-1:0] red_q, red_d;
  logic                  flash_q, flash_d;

  phase_t                next_phase;
  logic                  any_other;
  logic                  grant;
  logic [NUM_PHASES-1:0] grant_mask;

  tl_rr_picker #(
    .NUM_PHASES (NUM_PHASES)
  ) u_picker (
    .pend_i       (pend_q),
    .active_i     (active_q),
    .next_phase_o (next_phase),
    .any_other_o  (any_other)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    grant    = 1'b0;
    unique case (state_q)
      StAllRed: begin
        if (timer_q == AllRedM1) begin
          if (flash_en) begin
            state_d = StFlash;
          end else begin
            state_d  = StGreen;
            active_d = next_phase;
            grant    = 1'b1;
          end
        end
      end
      StGreen: begin
        // A green already past max (timer saturated) yields as soon as another approach waits.
        if (flash_en) begin
          state_d = StYellow;
        end else if (timer_q >= MinGreenM1 && any_other &&
                     (!req[active_q] || timer_q >= MaxGreenM1)) begin
          state_d = StYellow;
        end
      end
      StYellow: begin
        if (timer_q == YellowM1) state_d = StAllRed;
      end
      StFlash: begin
        if (!flash_en) state_d = StAllRed;
      end
      default: state_d = StAllRed;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == StFlash) begin
      timer_d = (timer_q == FlashLastT) ? '0 : timer_q + TIMER_W'(1);
    end else if (timer_q != '1) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Clear beats a new request only for the approach being granted this cycle.
  always_comb begin
    grant_mask = '0;
    if (grant) grant_mask[next_phase] = 1'b1;
    pend_d = (pend_q | req) & ~grant_mask;
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
    flash_d  = 1'b0;
    unique case (state_d)
      StGreen: begin
        green_d[active_d] = 1'b1;
        red_d[active_d]   = 1'b0;
      end
      StYellow: begin
        yellow_d[active_d] = 1'b1;
        red_d[active_d]    = 1'b0;
      end
      StFlash: begin
        red_d   = '0;
        flash_d = 1'b1;
        if (timer_d < FlashHalfT) yellow_d = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= StAllRed;
      timer_q  <= '0;
      active_q <= '0;
      pend_q   <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      flash_q  <= flash_d;
    end
  end

  assign green        = green_q;
  assign yellow       = yellow_q;
  assign red          = red_q;
  assign active_phase = active_q;
  assign flash_active = flash_q;

  a_lamp_excl: assert property (@(posedge clk) disable iff (!rstb)
    ((green_q & yellow_q) | (green_q & red_q) | (yellow_q & red_q)) == '0);
  a_one_open: assert property (@(posedge clk) disable iff (!rstb)
    !flash_q |-> $onehot0(~red_q));
  a_red_comp: assert property (@(posedge clk) disable iff (!rstb)
    !flash_q |-> (red_q == ~(green_q | yellow_q)));

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Randomized bench for traffic_phase_controller against a cycle-duration reference model.
module tb_traffic_phase_controller;

  localparam int NP    = 4;
  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YT    = 3;
  localparam int ART   = 2;
  localparam int FH    = 2;
  localparam int TW    = 8;

  // Model state labels (independent of the design's encoding).
  localparam int SAllRed = 0;
  localparam int SGreen  = 1;
  localparam int SYellow = 2;
  localparam int SFlash  = 3;

  logic          clk  = 1'b0;
  logic          rstb = 1'b1;
  logic [NP-1:0] req  = '0;
  logic          flash_en = 1'b0;
  logic [NP-1:0] green, yellow, red;
  logic [1:0]    active_phase;
  logic          flash_active;

  always #5 clk = ~clk;

  traffic_phase_controller #(
    .NUM_PHASES  (NP),
    .MIN_GREEN   (MIN_G),
    .MAX_GREEN   (MAX_G),
    .YELLOW_TIME (YT),
    .ALLRED_TIME (ART),
    .FLASH_HALF  (FH),
    .TIMER_W     (TW)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .req          (req),
    .flash_en     (flash_en),
    .green        (green),
    .yellow       (yellow),
    .red          (red),
    .active_phase (active_phase),
    .flash_active (flash_active)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state label, cycles spent in it so far, owner approach, pending flags.
  int m_state;
  int m_elapsed;
  int m_active;
  bit m_pend[NP];

  logic [NP-1:0] exp_g, exp_y, exp_r;
  logic          exp_fl;

  task automatic model_reset();
    m_state   = SAllRed;
    m_elapsed = 0;
    m_active  = 0;
    for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
  endtask

  function automatic int model_pick();
    for (int k = 1; k < NP; k++) begin
      if (m_pend[(m_active + k) % NP]) return (m_active + k) % NP;
    end
    return m_active;
  endfunction

  task automatic model_step(input logic [NP-1:0] r, input logic fl);
    int  ns;
    int  na;
    int  granted;
    int  dur;
    bit  others;
    bit  own_req;
    ns      = m_state;
    na      = m_active;
    granted = -1;
    dur     = m_elapsed + 1;
    others  = 1'b0;
    own_req = ((r >> m_active) & NP'(1)) != '0;
    for (int j = 0; j < NP; j++) begin
      if (j != m_active && m_pend[j]) others = 1'b1;
    end
    case (m_state)
      SAllRed: begin
        if (dur >= ART) begin
          if (fl) begin
            ns = SFlash;
          end else begin
            ns      = SGreen;
            na      = model_pick();
            granted = na;
          end
        end
      end
      SGreen: begin
        if (fl) ns = SYellow;
        else if (dur >= MIN_G && others && (!own_req || dur >= MAX_G)) ns = SYellow;
      end
      SYellow: if (dur >= YT) ns = SAllRed;
      default: if (!fl) ns = SAllRed;
    endcase
    for (int i = 0; i < NP; i++) begin
      m_pend[i] = (m_pend[i] || (((r >> i) & NP'(1)) != '0)) && (i != granted);
    end
    m_elapsed = (ns != m_state) ? 0 : m_elapsed + 1;
    m_state   = ns;
    m_active  = na;
  endtask

  task automatic model_outputs();
    exp_g  = '0;
    exp_y  = '0;
    exp_r  = '1;
    exp_fl = 1'b0;
    case (m_state)
      SGreen: begin
        exp_g = NP'(1) << m_active;
        exp_r = ~exp_g;
      end
      SYellow: begin
        exp_y = NP'(1) << m_active;
        exp_r = ~exp_y;
      end
      SFlash: begin
        exp_r  = '0;
        exp_fl = 1'b1;
        if ((m_elapsed % (2 * FH)) < FH) exp_y = '1;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all(input string tag);
    model_outputs();
    check_eq({tag, ".green"},  32'(green),        32'(exp_g));
    check_eq({tag, ".yellow"}, 32'(yellow),       32'(exp_y));
    check_eq({tag, ".red"},    32'(red),          32'(exp_r));
    check_eq({tag, ".active"}, 32'(active_phase), 32'(m_active));
    check_eq({tag, ".flash"},  32'(flash_active), 32'(exp_fl));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking outputs.
  task automatic run_cycle(input logic [NP-1:0] r, input logic fl);
    req      = r;
    flash_en = fl;
    @(posedge clk);
    model_step(r, fl);
    @(negedge clk);
    compare_all("run");
  endtask

  task automatic do_reset();
    #2;
    rstb = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    req      = '0;
    flash_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare_all("in_rst");
    rstb = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] r;
    logic          fl;
    bit            rst_done;
    int            kind;
    int            len;

    model_reset();
    #1 rstb = 1'b0;
    repeat (2) @(negedge clk);
    compare_all("reset");
    rstb = 1'b1;

    // Long idle: phase 0 must hold green with no demand, well past timer saturation.
    for (int c = 0; c < 300; c++) run_cycle('0, 1'b0);

    for (int s = 0; s < 40; s++) begin
      kind     = (s < 6) ? s : int'($urandom_range(0, 5));
      len      = int'($urandom_range(20, 80));
      rst_done = 1'b0;
      for (int c = 0; c < len; c++) begin
        r  = '0;
        fl = 1'b0;
        case (kind)
          0: ;
          1, 5: begin
            for (int i = 0; i < NP; i++) begin
              if ($urandom_range(0, 7) == 0) r = r | (NP'(1) << i);
            end
          end
          2: r = NP'($urandom);
          3: begin
            r = NP'(1) << m_active;
            if ($urandom_range(0, 9) == 0) r = r | (NP'(1) << $urandom_range(0, NP - 1));
          end
          default: begin
            fl = (c < len - 15);
            if ($urandom_range(0, 5) == 0) r = NP'(1) << $urandom_range(0, NP - 1);
          end
        endcase
        if (kind == 5 && !rst_done && m_state == SYellow) begin
          rst_done = 1'b1;
          do_reset();
        end else begin
          run_cycle(r, fl);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
